hdio_phy: RTL and testbench

- Behavioural, single-clock I/O front end for the HDMI/I2C board interface.
- Provides an open-drain SDA pad buffer with a 2-flop input synchroniser.
- Provides a fractional pixel-rate strobe generator (MULT/DIV phase accumulator, replacing the PLL ratio 14/19).
- Provides a same-edge DDR output stage that sends a 2*WIDTH-bit pixel over WIDTH pins per clk cycle.

---
 rtl/hdio_phy.sv | 112 +++++++++++
 tb/tb_hdio_phy.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/hdio_phy.sv
// HDMI/I2C board I/O front end: open-drain SDA pad with synchroniser,
// fractional pixel-rate strobe and same-edge DDR pixel output stage.
module hdio_phy #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned MULT  = 14,
    parameter int unsigned DIV   = 19
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 sdaout,
    inout  wire                  sda,
    output logic                 sdain,
    input  logic [2*WIDTH-1:0]   pixel,
    input  logic                 dein,
    output logic                 pixen,
    output logic [WIDTH-1:0]     hddat,
    output logic                 hdde
);

    localparam int unsigned ACC_W = $clog2(MULT + DIV) + 1;
    localparam int unsigned PIX_W = 2 * WIDTH;

    logic             r_s1;
    logic             r_sdain;
    logic [ACC_W-1:0] r_acc;
    logic             r_pixen;
    logic [PIX_W-1:0] r_hdd;
    logic             r_de1;
    logic [WIDTH-1:0] r_q1;
    logic [WIDTH-1:0] r_q2;
    logic [WIDTH-1:0] r_q2n;
    logic             r_hdde;
    logic             r_rst_q;

    logic             w_sda_in;
    logic [ACC_W-1:0] w_sum;
    logic             w_hit;

    // Open drain: only ever pull low, and let go while in reset.
    assign sda      = (!sdaout && rstn) ? 1'b0 : 1'bz;
    // A floating or unknown pad reads as the pulled-up idle level.
    assign w_sda_in = (sda === 1'b0) ? 1'b0 : 1'b1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_s1    <= 1'b1;
            r_sdain <= 1'b1;
        end else begin
            r_s1    <= w_sda_in;
            r_sdain <= r_s1;
        end
    end

    assign w_sum = r_acc + ACC_W'(MULT);
    assign w_hit = (w_sum >= ACC_W'(DIV));

    // Phase accumulator: wraps by DIV, firing MULT times per DIV cycles.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_acc   <= '0;
            r_pixen <= 1'b0;
        end else if (w_hit) begin
            r_acc   <= w_sum - ACC_W'(DIV);
            r_pixen <= 1'b1;
        end else begin
            r_acc   <= w_sum;
            r_pixen <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_hdd <= '0;
            r_de1 <= 1'b0;
        end else if (r_pixen) begin
            r_hdd <= pixel;
            r_de1 <= dein;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_q1   <= '0;
            r_q2   <= '0;
            r_hdde <= 1'b0;
        end else begin
            r_q1   <= r_hdd[WIDTH-1:0];
            r_q2   <= r_hdd[PIX_W-1:WIDTH];
            r_hdde <= r_de1;
        end
    end

    // Remembers a reset-sampled rising edge for the falling-edge register.
    always_ff @(posedge clk) begin
        r_rst_q <= ~rstn;
    end

    // Second half is re-timed to the falling edge so it is stable across the low phase.
    always_ff @(negedge clk) begin
        if (r_rst_q) begin
            r_q2n <= '0;
        end else begin
            r_q2n <= r_q2;
        end
    end

    assign hddat = clk ? r_q1 : r_q2n;
    assign sdain = r_sdain;
    assign pixen = r_pixen;
    assign hdde  = r_hdde;

endmodule

// File: tb/tb_hdio_phy.sv
// Self-checking bench for hdio_phy: directed steps plus random streaming
// compared against a cycle-level reference model.
module tb_hdio_phy;

    localparam int unsigned W = 12;
    localparam int unsigned M = 14;
    localparam int unsigned D = 19;

    logic           clk = 1'b0;
    logic           rstn;
    logic           sdaout;
    wire            sda;
    logic           sdain;
    logic [2*W-1:0] pixel;
    logic           dein;
    logic           pixen;
    logic [W-1:0]   hddat;
    logic           hdde;

    pullup (sda);

    hdio_phy #(.WIDTH(W), .MULT(M), .DIV(D)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .sdaout (sdaout),
        .sda    (sda),
        .sdain  (sdain),
        .pixel  (pixel),
        .dein   (dein),
        .pixen  (pixen),
        .hddat  (hddat),
        .hdde   (hdde)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int             m_k;
    logic           m_pixen;
    logic [2*W-1:0] m_cap;
    logic           m_cap_de;
    logic [2*W-1:0] m_out;
    logic           m_out_de;
    logic           m_s1;
    logic           m_sdain;
    logic           m_pad;

    // Last observed values, for directed constant checks
    logic [W-1:0]   o_hi;
    logic [W-1:0]   o_lo;
    logic           o_de;
    logic           o_pixen;
    logic           o_sdain;
    logic           o_sda;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe count after k edges is floor(k*M/D); pixen is the increment.
    function automatic logic strobe(input int k);
        return ((k * M) / D) != (((k - 1) * M) / D);
    endfunction

    task automatic cyc(input logic r, input logic so, input logic [2*W-1:0] px, input logic de);
        rstn   = r;
        sdaout = so;
        pixel  = px;
        dein   = de;
        m_pad  = (r && !so) ? 1'b0 : 1'b1;
        @(posedge clk);
        if (!r) begin
            m_k      = 0;
            m_pixen  = 1'b0;
            m_cap    = '0;
            m_cap_de = 1'b0;
            m_out    = '0;
            m_out_de = 1'b0;
            m_s1     = 1'b1;
            m_sdain  = 1'b1;
        end else begin
            m_out    = m_cap;
            m_out_de = m_cap_de;
            if (m_pixen) begin
                m_cap    = px;
                m_cap_de = de;
            end
            m_k++;
            m_pixen  = strobe(m_k);
            m_sdain  = m_s1;
            m_s1     = m_pad;
        end
        #1;
        o_hi    = hddat;
        o_de    = hdde;
        o_pixen = pixen;
        o_sdain = sdain;
        o_sda   = sda;
        chk("pixen",    32'(pixen), 32'(m_pixen));
        chk("hddat_hi", 32'(hddat), 32'(m_out[W-1:0]));
        chk("hdde",     32'(hdde),  32'(m_out_de));
        chk("sdain",    32'(sdain), 32'(m_sdain));
        chk("sda_pad",  32'(sda),   32'(m_pad));
        @(negedge clk);
        #1;
        o_lo = hddat;
        chk("hddat_lo", 32'(hddat), 32'(m_out[2*W-1:W]));
    endtask

    initial begin
        int ones;
        rstn   = 1'b0;
        sdaout = 1'b0;
        pixel  = '0;
        dein   = 1'b0;
        @(negedge clk);
        #1;

        // Reset with sdaout low: pad released, idle outputs
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 24'h5A5A5A, 1'b1);
        chk("rst_sda",   32'(o_sda),   32'd1);
        chk("rst_sdain", 32'(o_sdain), 32'd1);
        chk("rst_pixen", 32'(o_pixen), 32'd0);
        chk("rst_hddat", 32'(o_hi),    32'd0);
        chk("rst_hdde",  32'(o_de),    32'd0);

        // Edges 1..3: SDA driven low, ABC123 captured on edge 3 (pixen=1)
        cyc(1'b1, 1'b0, 24'h000000, 1'b0);
        chk("sda_low",     32'(o_sda),   32'd0);
        chk("sdain_e1",    32'(o_sdain), 32'd1);
        chk("strobe_e1",   32'(o_pixen), 32'd0);
        cyc(1'b1, 1'b0, 24'h000000, 1'b0);
        chk("sdain_e2",    32'(o_sdain), 32'd0);
        chk("strobe_e2",   32'(o_pixen), 32'd1);
        cyc(1'b1, 1'b0, 24'hABC123, 1'b1);
        chk("strobe_e3",   32'(o_pixen), 32'd1);
        cyc(1'b1, 1'b0, 24'hABC123, 1'b1);
        chk("ddr_first",   32'(o_hi),    32'h123);
        chk("ddr_second",  32'(o_lo),    32'hABC);
        chk("ddr_de",      32'(o_de),    32'd1);
        chk("strobe_e4",   32'(o_pixen), 32'd0);
        // Edge 5 has pixen=0: new pixel must not be taken
        cyc(1'b1, 1'b1, 24'h555555, 1'b0);
        chk("sda_release", 32'(o_sda),   32'd1);
        cyc(1'b1, 1'b1, 24'h555555, 1'b0);
        chk("hold_hi",     32'(o_hi),    32'h123);
        chk("hold_lo",     32'(o_lo),    32'hABC);
        chk("sdain_back",  32'(o_sdain), 32'd1);

        // Fresh reset, then count strobes over one full DIV period
        cyc(1'b0, 1'b1, 24'h0, 1'b0);
        ones = 0;
        for (int i = 0; i < int'(D); i++) begin
            cyc(1'b1, 1'(i[0]), 24'($urandom), 1'($urandom));
            ones += int'(o_pixen);
        end
        chk("strobes_per_div", 32'(ones), 32'(M));

        // Random streaming with a mid-run reset
        for (int i = 0; i < 200; i++) begin
            cyc((i == 120) ? 1'b0 : 1'b1, 1'($urandom_range(0, 1)),
                24'($urandom), 1'($urandom));
            if (i == 120) begin
                chk("midrst_hi", 32'(o_hi), 32'd0);
                chk("midrst_de", 32'(o_de), 32'd0);
            end
            if (i == 122) chk("midrst_seq_e2", 32'(o_pixen), 32'd1);
            if (i == 124) chk("midrst_seq_e4", 32'(o_pixen), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
